if_id_stall_ctrl: RTL and testbench

//  Consumer of the IF-stage hazard stall (if_stop) and the branch/mult-div control. Owns the IF/ID pipeline register.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/if_id_stall_ctrl_sat_counter.sv | 30 +++
 rtl/if_id_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_if_id_stall_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared front-end control definitions: the stall FSM state encoding and the bubble instruction word.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_MDW   = 2'd2,
    ST_FLUSH = 2'd3
  } ctrl_state_e;

  localparam logic [31:0] NOP_INST_C = 32'h0000_0000;

endpackage

// File: rtl/if_id_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
`timescale 1ns/1ps
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline register with hazard / mult-div stall and branch flush control.
// Optional STALL_PERF_CNT_EN adds saturating stall_cnt and flush_cnt outputs.
`timescale 1ns/1ps
module if_id_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 1,
  parameter int          MD_TIMEOUT   = 64,
  parameter logic [31:0] NOP_INST     = NOP_INST_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        if_stop,
  input  logic        md_busy,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        ex_bubble,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        md_timeout
);

  localparam int         WAIT_W     = $clog2(MD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MD_TIMEOUT - 1);
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  ctrl_state_e      st_q, st_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic             id_valid_q, id_valid_d;
  logic             md_timeout_q, md_timeout_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]       fl_cnt;

  logic stop_eff, do_mdw, do_haz, squash;

  // An empty ID slot cannot be the consumer of a hazard, so its stall request is dropped.
  assign stop_eff = if_stop & id_valid_q;
  assign do_mdw   = ~branch_taken & md_busy;
  assign do_haz   = ~branch_taken & ~md_busy & stop_eff;
  assign squash   = ~branch_taken & ~md_busy & ~stop_eff &
                    (st_q == ST_FLUSH) & (fl_cnt < FLUSH_LAST);

  assign pc_we     = rst_n & (branch_taken | (~md_busy & ~stop_eff));
  assign ex_bubble = rst_n & do_haz;

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~do_mdw),
    .inc   (do_mdw),
    .cnt   (wait_cnt)
  );

  sat_counter #(.WIDTH(2)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (branch_taken),
    .inc   (squash),
    .cnt   (fl_cnt)
  );

  always_comb begin
    st_d         = ST_RUN;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    md_timeout_d = md_timeout_q;
    if (branch_taken) begin
      st_d       = ST_FLUSH;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (md_busy) begin
      st_d = ST_MDW;
      if (wait_cnt >= WAIT_LAST)
        md_timeout_d = 1'b1;
    end else if (stop_eff) begin
      st_d = ST_HAZ;
    end else if (squash) begin
      st_d       = ((fl_cnt + 2'd1) < FLUSH_LAST) ? ST_FLUSH : ST_RUN;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else begin
      id_inst_d  = if_inst;
      id_pc_d    = if_pc;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q         <= ST_RUN;
      id_inst_q    <= NOP_INST;
      id_pc_q      <= 32'h0;
      id_valid_q   <= 1'b0;
      md_timeout_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      id_valid_q   <= id_valid_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign id_inst    = id_inst_q;
  assign id_pc      = id_pc_q;
  assign id_valid   = id_valid_q;
  assign md_timeout = md_timeout_q;

`ifdef STALL_PERF_CNT_EN
  sat_counter #(.WIDTH(32)) u_stall_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (do_mdw | do_haz),
    .cnt   (stall_cnt)
  );

  sat_counter #(.WIDTH(32)) u_flush_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (branch_taken),
    .cnt   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Bench for if_id_stall_ctrl: directed scenarios then random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_if_id_stall_ctrl;

  localparam int          FC  = 2;
  localparam int          MDT = 64;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_inst = 32'h0;
  logic [31:0] if_pc = 32'h0;
  logic        if_stop = 1'b0;
  logic        md_busy = 1'b0;
  logic        branch_taken = 1'b0;
  logic        pc_we, id_valid, ex_bubble, md_timeout;
  logic [31:0] id_inst, id_pc;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  if_id_stall_ctrl #(.FLUSH_CYCLES(FC), .MD_TIMEOUT(MDT), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .if_stop      (if_stop),
    .md_busy      (md_busy),
    .branch_taken (branch_taken),
    .pc_we        (pc_we),
    .id_inst      (id_inst),
    .id_pc        (id_pc),
    .id_valid     (id_valid),
    .ex_bubble    (ex_bubble),
`ifdef STALL_PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .md_timeout   (md_timeout)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: architectural view of the IF/ID slot plus run-length bookkeeping.
  logic [31:0] m_inst = NOP;
  logic [31:0] m_pc = 32'h0;
  bit          m_valid = 1'b0;
  bit          m_to = 1'b0;
  int          busy_run = 0;
  int          squash_left = 0;
  int          stall_m = 0;
  int          flush_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit b, input bit m, input bit s);
    logic [31:0] ins, pc;
    bit stop;
    @(negedge clk);
    ins = $urandom;
    pc  = $urandom & 32'hFFFF_FFFC;
    rst_n = r; branch_taken = b; md_busy = m; if_stop = s;
    if_inst = ins; if_pc = pc;
    #1;
    stop = s && m_valid;
    check("pc_we", 32'(pc_we), 32'(r && (b || (!m && !stop))));
    check("ex_bubble", 32'(ex_bubble), 32'(r && !b && !m && stop));
    @(posedge clk);
    if (!r) begin
      m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0; m_to = 1'b0;
      busy_run = 0; squash_left = 0; stall_m = 0; flush_m = 0;
    end else begin
      if (b) flush_m++;
      else if (m || stop) stall_m++;
      if (b) begin
        m_inst = NOP; m_valid = 1'b0; squash_left = FC - 1; busy_run = 0;
      end else if (m) begin
        busy_run++;
        if (busy_run >= MDT) m_to = 1'b1;
        squash_left = 0;
      end else if (stop) begin
        busy_run = 0;
      end else if (squash_left > 0) begin
        m_inst = NOP; m_valid = 1'b0; squash_left--; busy_run = 0;
      end else begin
        m_inst = ins; m_pc = pc; m_valid = 1'b1; busy_run = 0;
      end
    end
    #1;
    check("id_inst", id_inst, m_inst);
    check("id_pc", id_pc, m_pc);
    check("id_valid", 32'(id_valid), 32'(m_valid));
    check("md_timeout", 32'(md_timeout), 32'(m_to));
`ifdef STALL_PERF_CNT_EN
    check("stall_cnt", stall_cnt, stall_m);
    check("flush_cnt", flush_cnt, flush_m);
`endif
  endtask

  logic [31:0] held_pc;

  initial begin
    // Reset held for three cycles, then first RUN cycle.
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_id_inst", id_inst, NOP);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Two-cycle hazard stall with a valid ID slot.
    held_pc = id_pc;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("haz_pc_held", id_pc, held_pc);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("haz_resume_valid", 32'(id_valid), 32'h1);

    // Branch together with hazard: flush wins, two NOP loads.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("flush_nop0", id_inst, NOP);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("flush_valid1", 32'(id_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("flush_done", 32'(id_valid), 32'h1);

    // Long mult/div wait crossing the timeout, then release.
    repeat (70) step(1'b1, 1'b0, 1'b1, 1'b0);
    check("md_timeout_set", 32'(md_timeout), 32'h1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("md_timeout_sticky", 32'(md_timeout), 32'h1);

    // Reset mid-wait.
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_mdw_timeout", 32'(md_timeout), 32'h0);
    check("rst_mdw_valid", 32'(id_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_mdw_run", 32'(id_valid), 32'h1);

`ifdef STALL_PERF_CNT_EN
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("perf_stall5", stall_cnt, 32'd5);
    check("perf_flush2", flush_cnt, 32'd2);
`endif

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(99) >= 3,
           $urandom_range(99) < 10,
           $urandom_range(99) < 15,
           $urandom_range(99) < 35);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
